// File: rtl/tuman_mem_pkg.sv
// Shared types and constants for the TuMan32 data-bus router.
package tuman_mem_pkg;

  localparam int unsigned MAX_PORTS  = 8;
  localparam int unsigned WORD_SHIFT = 2;
  localparam int unsigned MAX_RD_LAT = 4;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned ADDR_W     = 32;

  // Read-return tag carried alongside an outstanding read
  typedef struct packed {
    logic             valid;
    logic             mapped;
    logic [IDX_W-1:0] idx;
  } tag_t;

  function automatic logic [ADDR_W-1:0] to_word_addr(input logic [ADDR_W-1:0] byte_addr);
    return byte_addr >> WORD_SHIFT;
  endfunction

endpackage

// File: rtl/tuman_tag_pipe.sv
// Fixed-depth shift register of read tags; synchronous reset clears every stage.
module tuman_tag_pipe
  import tuman_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [DEPTH-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= tag_in;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/tuman_mem_router.sv
// Data-bus router: address decode to NUM_PORTS targets, tagged read return.
// Optional unmapped-access reporting is built when MEM_ROUTER_ERR_EN is defined.
module tuman_mem_router
  import tuman_mem_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned SEL_W     = 1,
  parameter int unsigned DW        = 32,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_wren,
  input  logic                    mem_rden,
  input  logic [31:0]             mem_addr,
  input  logic [DW-1:0]           mem_wdata,
  input  logic [DW/8-1:0]         mem_wstrb,
  output logic [DW-1:0]           mem_rdata,
  output logic                    mem_rdata_valid,
  output logic [NUM_PORTS-1:0]    tgt_wren,
  output logic [NUM_PORTS-1:0]    tgt_rden,
  output logic [31:0]             tgt_addr,
  output logic [DW-1:0]           tgt_wdata,
  output logic [DW/8-1:0]         tgt_wstrb,
  input  logic [NUM_PORTS*DW-1:0] tgt_rdata,
  output logic                    err_valid,
  output logic [31:0]             err_addr
);

  logic [SEL_W-1:0] sel;
  logic             mapped;
  tag_t             tag_in;
  tag_t             tag_out;
  logic [DW-1:0]    port_rdata [NUM_PORTS];
  logic [DW-1:0]    sel_rdata;
  logic [DW-1:0]    rdata_q;

  assign sel    = mem_addr[31 -: SEL_W];
  assign mapped = 32'(sel) < NUM_PORTS;

  // Request decode is purely combinational so targets see the access in the same cycle
  always_comb begin
    tgt_wren = '0;
    tgt_rden = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (32'(sel) == i) begin
        tgt_wren[i] = mem_wren;
        tgt_rden[i] = mem_rden;
      end
    end
  end

  assign tgt_addr  = to_word_addr(mem_addr);
  assign tgt_wdata = mem_wdata;
  assign tgt_wstrb = mem_wstrb;

  assign tag_in = '{valid: mem_rden, mapped: mapped, idx: IDX_W'(sel)};

  tuman_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port_rdata
    assign port_rdata[g] = tgt_rdata[g*DW +: DW];
  end

  // Unmapped reads resolve to zero so the core still gets a response
  always_comb begin
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (tag_out.mapped && (tag_out.idx == IDX_W'(i))) begin
        sel_rdata = port_rdata[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (tag_out.valid) begin
      rdata_q <= sel_rdata;
    end
  end

  assign mem_rdata_valid = tag_out.valid;
  assign mem_rdata       = tag_out.valid ? sel_rdata : rdata_q;

`ifdef MEM_ROUTER_ERR_EN
  logic unmapped_acc;
  logic err_seen_q;

  assign unmapped_acc = !mapped && (mem_wren || mem_rden);

  // err_addr keeps the first offender until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      err_valid  <= 1'b0;
      err_addr   <= '0;
      err_seen_q <= 1'b0;
    end else begin
      err_valid <= unmapped_acc;
      if (unmapped_acc && !err_seen_q) begin
        err_addr   <= mem_addr;
        err_seen_q <= 1'b1;
      end
    end
  end
`else
  assign err_valid = 1'b0;
  assign err_addr  = '0;
`endif

endmodule
